// File: rtl/dmi_master_arbiter_if.sv
// dmi_master_arbiter_if: requester handshakes plus the TileLink-UL DMI A/D channels seen by dmi_master_arbiter
interface dmi_master_arbiter_if #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 32
);
  logic [1:0]          req_valid;
  logic [1:0]          req_ready;
  logic [1:0]          req_write;
  logic [2*ADDR_W-1:0] req_addr;
  logic [2*DATA_W-1:0] req_data;
  logic [1:0]          rsp_valid;
  logic [1:0]          rsp_ready;
  logic [DATA_W-1:0]   rsp_data;
  logic                rsp_error;
  logic                dmi_a_valid;
  logic                dmi_a_ready;
  logic [2:0]          dmi_a_opcode;
  logic [ADDR_W-1:0]   dmi_a_address;
  logic [DATA_W-1:0]   dmi_a_data;
  logic                dmi_d_valid;
  logic                dmi_d_ready;
  logic [2:0]          dmi_d_opcode;
  logic [DATA_W-1:0]   dmi_d_data;
  modport master (
    input  req_valid, req_write, req_addr, req_data, rsp_ready,
           dmi_a_ready, dmi_d_valid, dmi_d_opcode, dmi_d_data,
    output req_ready, rsp_valid, rsp_data, rsp_error,
           dmi_a_valid, dmi_a_opcode, dmi_a_address, dmi_a_data, dmi_d_ready
  );
  modport slave (
    output req_valid, req_write, req_addr, req_data, rsp_ready,
           dmi_a_ready, dmi_d_valid, dmi_d_opcode, dmi_d_data,
    input  req_ready, rsp_valid, rsp_data, rsp_error,
           dmi_a_valid, dmi_a_opcode, dmi_a_address, dmi_a_data, dmi_d_ready
  );
endinterface

// File: rtl/dmi_master_arbiter.sv
// dmi_master_arbiter: round-robin two-requester DMI sequencer, one transaction outstanding; define DMI_TIMEOUT_EN to add the response watchdog
module dmi_master_arbiter #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                 clock,
  input  logic                 reset,
  dmi_master_arbiter_if.master bus,
  output logic [7:0]           stray_cnt
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_D, RESP} state_t;
  state_t            state, state_nx;
  logic              last_grant, grant, wr_q, rsp_error_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q, rsp_data_q;
  logic              win, req_fire, a_fire, d_fire, busy, timeout, capture, rsp_done;
  assign win = &bus.req_valid ? ~last_grant : bus.req_valid[1];
  assign req_fire = state == IDLE && |bus.req_valid;
  assign a_fire = bus.dmi_a_valid & bus.dmi_a_ready;
  assign d_fire = bus.dmi_d_valid & bus.dmi_d_ready;
  assign busy = state == ISSUE || state == WAIT_D;
  assign capture = (state == ISSUE && a_fire && d_fire) || (state == WAIT_D && d_fire);
  assign rsp_done = state == RESP && bus.rsp_ready[grant];
`ifdef DMI_TIMEOUT_EN
  logic [7:0] wd_cnt;
  assign timeout = busy && wd_cnt == 8'(TIMEOUT_CYCLES);
  // watchdog restarts when a request is latched and counts every in-flight cycle
  always_ff @(posedge clock or posedge reset)
    if (reset) wd_cnt <= '0;
    else if (req_fire) wd_cnt <= '0;
    else if (busy) wd_cnt <= wd_cnt + 8'd1;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign timeout = 1'b0;
`endif
  // state register
  always_ff @(posedge clock or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_nx;
  // next-state logic; a watchdog expiry is reported as an errored response
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = req_fire ? ISSUE : IDLE;
      ISSUE:   state_nx = (timeout || capture) ? RESP : a_fire ? WAIT_D : ISSUE;
      WAIT_D:  state_nx = (timeout || capture) ? RESP : WAIT_D;
      RESP:    state_nx = rsp_done ? IDLE : RESP;
      default: state_nx = IDLE;
    endcase
  end
  // latch the winning request and remember who was served last for round-robin
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      grant      <= 1'b0;
      wr_q       <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      last_grant <= 1'b1;
    end else begin
      if (req_fire) begin
        grant  <= win;
        wr_q   <= bus.req_write[win];
        addr_q <= win ? bus.req_addr[2*ADDR_W-1:ADDR_W] : bus.req_addr[ADDR_W-1:0];
        data_q <= win ? bus.req_data[2*DATA_W-1:DATA_W] : bus.req_data[DATA_W-1:0];
      end
      if (rsp_done) last_grant <= grant;
    end
  // capture the D beat: writes return no data, wrong opcode flags an error
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      rsp_data_q  <= '0;
      rsp_error_q <= 1'b0;
    end else if (capture) begin
      rsp_data_q  <= wr_q ? '0 : bus.dmi_d_data;
      rsp_error_q <= bus.dmi_d_opcode != (wr_q ? 3'h0 : 3'h1);
    end else if (timeout) begin
      rsp_data_q  <= '0;
      rsp_error_q <= 1'b1;
    end
  // D beats accepted while idle belong to no transaction; count them, saturating
  always_ff @(posedge clock or posedge reset)
    if (reset) stray_cnt <= '0;
    else if (state == IDLE && d_fire && stray_cnt != 8'hff) stray_cnt <= stray_cnt + 8'd1;
  // outputs decoded from state; idle-time readies are held low while reset is asserted
  always_comb begin
    bus.req_ready     = (state == IDLE && !reset && |bus.req_valid) ? (win ? 2'b10 : 2'b01) : 2'b00;
    bus.rsp_valid     = state == RESP ? (grant ? 2'b10 : 2'b01) : 2'b00;
    bus.rsp_data      = rsp_data_q;
    bus.rsp_error     = rsp_error_q;
    bus.dmi_a_valid   = state == ISSUE && !timeout;
    bus.dmi_a_opcode  = (state == ISSUE && !wr_q) ? 3'h4 : 3'h0;
    bus.dmi_a_address = addr_q;
    bus.dmi_a_data    = data_q;
    bus.dmi_d_ready   = !reset && !timeout && state != RESP;
  end
endmodule

// File: tb/tb_dmi_master_arbiter.sv
// tb_dmi_master_arbiter: queue-driven requesters, zero-wait slave model and scoreboard monitors for dmi_master_arbiter
module tb_dmi_master_arbiter;
  localparam int AW = 7;
  localparam int DW = 32;
  typedef struct { logic wr; logic [AW-1:0] addr; logic [DW-1:0] data; } req_t;
  typedef struct { logic [2:0] op; logic [AW-1:0] addr; logic [DW-1:0] data; } a_t;
  typedef struct { int idx; logic [DW-1:0] data; logic err; } r_t;
  logic clock = 0;
  logic reset = 1;
  logic [7:0] stray_cnt;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_acc = 0, last_a = 0, last_r = 0, a_len = 0, a_run = 0;
  req_t req_q[2][$];
  a_t a_q[$];
  r_t r_q[$];
  logic a_rdy = 1, d_en = 1, inject = 0;
  logic [2:0] rd_op = 3'h1, wr_op = 3'h0;
  logic [DW-1:0] rd_data = '0;
  dmi_master_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus();
  dmi_master_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(10)) dut (
    .clock(clock), .reset(reset), .bus(bus), .stray_cnt(stray_cnt));
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;
  assign bus.rsp_ready = 2'b11;
  assign bus.dmi_a_ready = a_rdy;
  assign bus.dmi_d_valid = (bus.dmi_a_valid & a_rdy & d_en) | inject;
  assign bus.dmi_d_opcode = bus.dmi_a_opcode == 3'h4 ? rd_op : wr_op;
  assign bus.dmi_d_data = rd_data;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask
  task automatic push_req(input int i, input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] data);
    req_t t;
    t.wr = wr; t.addr = addr; t.data = data;
    req_q[i].push_back(t);
  endtask
  task automatic exp_a(input logic [2:0] op, input logic [AW-1:0] addr, input logic [DW-1:0] data);
    a_t t;
    t.op = op; t.addr = addr; t.data = data;
    a_q.push_back(t);
  endtask
  task automatic exp_r(input int idx, input logic [DW-1:0] data, input logic err);
    r_t t;
    t.idx = idx; t.data = data; t.err = err;
    r_q.push_back(t);
  endtask
  task automatic drain();
    int n = 0;
    while ((a_q.size() != 0 || r_q.size() != 0 || req_q[0].size() != 0 || req_q[1].size() != 0) && n < 400) begin
      @(negedge clock);
      n++;
    end
    if (n >= 400) begin
      checks++; errors++;
      $display("FAIL drain: %0d A and %0d responses still expected after %0d cycles", a_q.size(), r_q.size(), n);
      a_q.delete(); r_q.delete();
    end
    repeat (2) @(negedge clock);
  endtask

  for (genvar g = 0; g < 2; g++) begin : drv
    logic rv = 0, rw = 0;
    logic [AW-1:0] ra = '0;
    logic [DW-1:0] rd = '0;
    assign bus.req_valid[g] = rv;
    assign bus.req_write[g] = rw;
    assign bus.req_addr[g*AW +: AW] = ra;
    assign bus.req_data[g*DW +: DW] = rd;
    initial begin
      int w;
      logic h;
      req_t t;
      w = 0;
      forever begin
        @(negedge clock);
        h = rv & bus.req_ready[g];
        @(posedge clock);
        #1;
        if (h) rv = 0;
        if (rv) begin
          w++;
          if (w > 200) begin
            checks++; errors++;
            $display("FAIL req%0d_accept: not accepted after %0d cycles", g, w);
            rv = 0;
          end
        end
        if (!rv && req_q[g].size() != 0) begin
          t = req_q[g].pop_front();
          rw = t.wr; ra = t.addr; rd = t.data; rv = 1; w = 0;
        end
      end
    end
  end

  initial begin : monitor
    a_t t, held;
    r_t r;
    logic stall;
    stall = 0;
    forever begin
      @(negedge clock);
      if (reset) begin
        stall = 0; a_run = 0;
      end else begin
        if (|(bus.req_valid & bus.req_ready)) last_acc = cyc;
        if (bus.req_ready != 2'b00) check("req_ready_onehot", 64'($countones(bus.req_ready)), 1);
        if (stall) begin
          check("a_hold_valid", bus.dmi_a_valid, 1);
          check("a_hold_opcode", bus.dmi_a_opcode, held.op);
          check("a_hold_address", bus.dmi_a_address, held.addr);
          check("a_hold_data", bus.dmi_a_data, held.data);
        end
        stall = bus.dmi_a_valid & ~bus.dmi_a_ready;
        held.op = bus.dmi_a_opcode; held.addr = bus.dmi_a_address; held.data = bus.dmi_a_data;
        if (bus.dmi_a_valid) a_run++;
        if (bus.dmi_a_valid && bus.dmi_a_ready) begin
          a_len = a_run; a_run = 0; last_a = cyc;
          if (a_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL a_unexpected: got addr %0h, none expected", bus.dmi_a_address);
          end else begin
            t = a_q.pop_front();
            check("a_opcode", bus.dmi_a_opcode, t.op);
            check("a_address", bus.dmi_a_address, t.addr);
            check("a_data", bus.dmi_a_data, t.data);
          end
        end
        for (int i = 0; i < 2; i++)
          if (bus.rsp_valid[i] && bus.rsp_ready[i]) begin
            last_r = cyc;
            if (r_q.size() == 0) begin
              checks++; errors++;
              $display("FAIL rsp_unexpected: got rsp on requester %0d, none expected", i);
            end else begin
              r = r_q.pop_front();
              check("rsp_requester", 64'(i), 64'(r.idx));
              check("rsp_data", bus.rsp_data, r.data);
              check("rsp_error", bus.rsp_error, r.err);
            end
          end
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int n;
    repeat (3) @(negedge clock);
    check("rst_req_ready", bus.req_ready, 0);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_a_valid", bus.dmi_a_valid, 0);
    check("rst_d_ready", bus.dmi_d_ready, 0);
    check("rst_a_opcode", bus.dmi_a_opcode, 0);
    check("rst_rsp_data", bus.rsp_data, 0);
    check("rst_rsp_error", bus.rsp_error, 0);
    check("rst_stray", stray_cnt, 0);
    @(posedge clock); #1 reset = 0;
    // single read by requester 0, zero-wait slave
    rd_op = 3'h1; rd_data = 32'h3;
    push_req(0, 0, 7'h10, 0); exp_a(3'h4, 7'h10, 0); exp_r(0, 32'h3, 0);
    drain();
    check("t1_a_latency", 64'(last_a - last_acc), 1);
    check("t1_rsp_latency", 64'(last_r - last_acc), 2);
    // read answered with the wrong opcode: error, data still passed through
    rd_op = 3'h0; rd_data = 32'hFFFF_FFFF;
    push_req(1, 0, 7'h22, 0); exp_a(3'h4, 7'h22, 0); exp_r(1, 32'hFFFF_FFFF, 1);
    drain();
    // both requesters writing back to back alternate 0,1,0,1
    rd_op = 3'h1;
    push_req(0, 1, 7'h10, 32'hA); push_req(0, 1, 7'h10, 32'hA);
    push_req(1, 1, 7'h10, 32'hB); push_req(1, 1, 7'h10, 32'hB);
    exp_a(3'h0, 7'h10, 32'hA); exp_a(3'h0, 7'h10, 32'hB); exp_a(3'h0, 7'h10, 32'hA); exp_a(3'h0, 7'h10, 32'hB);
    exp_r(0, 0, 0); exp_r(1, 0, 0); exp_r(0, 0, 0); exp_r(1, 0, 0);
    drain();
    // A channel back-pressured for 5 cycles
    a_rdy = 0;
    push_req(0, 1, 7'h05, 32'h1234_5678); exp_a(3'h0, 7'h05, 32'h1234_5678); exp_r(0, 0, 0);
    n = 0;
    do begin @(negedge clock); n++; end while (!bus.dmi_a_valid && n < 50);
    repeat (4) @(negedge clock);
    @(posedge clock); #1 a_rdy = 1;
    drain();
    check("t4_a_hold_cycles", 64'(a_len), 6);
    // writes: AccessAck is clean, AccessAckData is an error, data always 0
    wr_op = 3'h0;
    push_req(1, 1, 7'h07, 32'hCAFE); exp_a(3'h0, 7'h07, 32'hCAFE); exp_r(1, 0, 0);
    drain();
    wr_op = 3'h1;
    push_req(0, 1, 7'h08, 32'h55); exp_a(3'h0, 7'h08, 32'h55); exp_r(0, 0, 1);
    drain();
    wr_op = 3'h0;
    // reset while waiting on D aborts silently and restores requester-0 priority
    d_en = 0;
    push_req(1, 0, 7'h09, 0); exp_a(3'h4, 7'h09, 0);
    n = 0;
    while (a_q.size() != 0 && n < 50) begin @(negedge clock); n++; end
    @(negedge clock);
    check("t7_wait_d_ready", bus.dmi_d_ready, 1);
    reset = 1;
    #1;
    check("t7_rst_rsp_valid", bus.rsp_valid, 0);
    check("t7_rst_a_valid", bus.dmi_a_valid, 0);
    check("t7_rst_d_ready", bus.dmi_d_ready, 0);
    check("t7_rst_req_ready", bus.req_ready, 0);
    repeat (2) @(posedge clock);
    #1 reset = 0; d_en = 1; rd_data = 32'h77;
    push_req(0, 0, 7'h11, 0); push_req(1, 0, 7'h12, 0);
    exp_a(3'h4, 7'h11, 0); exp_a(3'h4, 7'h12, 0);
    exp_r(0, 32'h77, 0); exp_r(1, 32'h77, 0);
    drain();
    // D beats arriving while idle are counted and saturate
    @(posedge clock); #1 inject = 1;
    @(posedge clock); #1 inject = 0;
    @(negedge clock);
    check("stray_one", stray_cnt, 1);
    inject = 1;
    repeat (260) @(posedge clock);
    #1 inject = 0;
    @(negedge clock);
    check("stray_saturate", stray_cnt, 255);
`ifdef DMI_TIMEOUT_EN
    // unanswered read times out with an error, the late beat is counted as stray
    @(posedge clock); #1 reset = 1;
    @(posedge clock); #1 reset = 0; d_en = 0;
    push_req(0, 0, 7'h13, 0); exp_a(3'h4, 7'h13, 0); exp_r(0, 0, 1);
    drain();
    check("to_rsp_latency", 64'(last_r - last_acc), 12);
    @(posedge clock); #1 inject = 1;
    @(posedge clock); #1 inject = 0; d_en = 1;
    @(negedge clock);
    check("to_stray", stray_cnt, 1);
`endif
    check("leftover_expected", 64'(a_q.size() + r_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
